controlador_interrupciones_8: RTL and testbench



---
 rtl/controlador_interrupciones_8_pkg.sv | 23 ++
 rtl/controlador_interrupciones_8_if.sv | 23 ++
 rtl/controlador_interrupciones_8_codificador_prioridad_8.sv | 17 +
 rtl/controlador_interrupciones_8.sv | 119 +++++++++++
 tb/tb_controlador_interrupciones_8.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_interrupciones_8_pkg.sv
// Shared types and constants for the 8-source interrupt sequencer.
// Holds FSM encodings, code constants and the rotate helper.
package controlador_interrupciones_8_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        ISSUE = 2'd2
    } estado_t;

    localparam logic [3:0] CODE_NONE = 4'b0000;
    localparam int         VALID     = 3;

    function automatic logic [7:0] rotr8(
        input logic [7:0] v,
        input logic [2:0] s
    );
        logic [15:0] d;
        d = {v, v} >> s;
        return d[7:0];
    endfunction

endpackage

// File: rtl/controlador_interrupciones_8_if.sv
// Request/grant bundle between the sources, the sequencer and the consumer.
// slave is the sequencer side, master is the board/consumer side.
interface controlador_interrupciones_8_if;

    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic       irq;
    logic [3:0] code;
    logic [7:0] pend;
    logic       err;

    modport master (
        output req, mask, ack,
        input  irq, code, pend, err
    );

    modport slave (
        input  req, mask, ack,
        output irq, code, pend, err
    );

endinterface

// File: rtl/controlador_interrupciones_8_codificador_prioridad_8.sv
// Combinational 8-to-{valid, idx} encoder, lowest set bit wins.
// Yields CODE_NONE when no input bit is set.
module codificador_prioridad_8
    import controlador_interrupciones_8_pkg::*;
(
    input  logic [7:0] v,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_NONE;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) code = {1'b1, 3'(i)};
        end
    end

endmodule

// File: rtl/controlador_interrupciones_8.sv
// Round-robin interrupt sequencer: edge capture, pending/mask,
// one grant at a time with ack handshake and optional timeout.
module controlador_interrupciones_8
    import controlador_interrupciones_8_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int N_FUENTES = 8
) (
    input logic clk,
    input logic rst_n,
    controlador_interrupciones_8_if.slave bus
);

    localparam logic [7:0] TO_LAST =
        8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    estado_t state, state_n;

    logic [N_FUENTES-1:0] req_q, pending, pending_n;
    logic [N_FUENTES-1:0] rise, elig, clr, rot;
    logic [2:0]           ptr, ptr_n, idx, idx_n, sel;
    logic [7:0]           cnt, cnt_n;
    logic [3:0]           enc;
    logic                 irq_q, irq_n, err_q, err_n;
    logic [3:0]           code_q, code_n;

    assign rise = bus.req & ~req_q;
    assign elig = pending & ~bus.mask;
    assign rot  = rotr8(elig, ptr);
    assign sel  = enc[2:0] + ptr;

    codificador_prioridad_8 u_enc (
        .v    (rot),
        .code (enc)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        ptr_n   = ptr;
        cnt_n   = cnt;
        clr     = '0;
        irq_n   = irq_q;
        code_n  = code_q;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                irq_n  = 1'b0;
                code_n = CODE_NONE;
                if (|elig) state_n = ARB;
            end
            ARB: begin
                // mask may have changed since IDLE; fall back if nothing left
                if (enc[VALID]) begin
                    idx_n   = sel;
                    cnt_n   = '0;
                    irq_n   = 1'b1;
                    code_n  = {1'b1, sel};
                    state_n = ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (bus.ack) begin
                    clr      = 8'(1) << idx;
                    ptr_n    = idx + 3'd1;
                    irq_n    = 1'b0;
                    code_n   = CODE_NONE;
                    state_n  = IDLE;
                end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
                    err_n    = 1'b1;
                    ptr_n    = idx + 3'd1;
                    irq_n    = 1'b0;
                    code_n   = CODE_NONE;
                    state_n  = IDLE;
                end else begin
                    cnt_n    = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
        // a new rising edge outranks a same-cycle clear
        pending_n = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            irq_q   <= 1'b0;
            code_q  <= CODE_NONE;
            err_q   <= 1'b0;
        end else begin
            req_q   <= bus.req;
            pending <= pending_n;
            ptr     <= ptr_n;
            idx     <= idx_n;
            cnt     <= cnt_n;
            irq_q   <= irq_n;
            code_q  <= code_n;
            err_q   <= err_n;
        end
    end

    assign bus.irq  = irq_q;
    assign bus.code = code_q;
    assign bus.pend = pending;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_controlador_interrupciones_8.sv
// Bench for the round-robin interrupt sequencer: directed scenarios
// plus random traffic, all checked by a queue-based scoreboard.
module tb_controlador_interrupciones_8;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    controlador_interrupciones_8_if bus ();

    controlador_interrupciones_8 #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
        end
    endtask

    // Reference model: pending set, pointer, and a first-eligible-from-pointer scan.
    logic [7:0] m_req_q, m_pend, m_rise, m_elig, m_clr;
    int m_ptr, m_idx, m_cnt, m_phase;
    int gq[$];
    int eq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_q = '0; m_pend = '0;
            m_ptr = 0; m_idx = 0; m_cnt = 0; m_phase = 0;
            gq.delete(); eq.delete();
        end else begin
            m_rise = bus.req & ~m_req_q;
            m_elig = m_pend & ~bus.mask;
            m_clr  = '0;
            case (m_phase)
                0: if (m_elig != 0) m_phase = 1;
                1: begin
                    m_phase = 0;
                    for (int k = 0; k < 8; k++)
                        if (m_phase == 0 && m_elig[(m_ptr + k) % 8]) begin
                            m_idx = (m_ptr + k) % 8;
                            m_phase = 2;
                        end
                    if (m_phase == 2) begin
                        m_cnt = 0;
                        gq.push_back(8 + m_idx);
                    end
                end
                default: begin
                    if (bus.ack) begin
                        m_clr[m_idx] = 1'b1;
                        m_ptr = (m_idx + 1) % 8;
                        m_phase = 0;
                    end else if (m_cnt == TO - 1) begin
                        eq.push_back(m_idx);
                        m_ptr = (m_idx + 1) % 8;
                        m_phase = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
            m_pend = (m_pend & ~m_clr) | m_rise;
            m_req_q = bus.req;
        end
    end

    // Monitor: pops expected grants/timeouts whenever the DUT shows them.
    logic       prev_irq = 1'b0;
    logic [3:0] last_code = '0;
    int         seen[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_irq = 1'b0;
        end else begin
            chk("pend", int'(bus.pend), int'(m_pend));
            chk("irq_vs_valid", int'(bus.irq), int'(bus.code[3]));
            if (bus.irq && !prev_irq) begin
                if (gq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_grant: got code %0d expected none", bus.code);
                end else begin
                    chk("grant_code", int'(bus.code), gq.pop_front());
                end
                last_code = bus.code;
                seen.push_back(int'(bus.code));
            end else if (bus.irq) begin
                chk("code_hold", int'(bus.code), int'(last_code));
            end
            if (bus.err) begin
                if (eq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_err: got err=1 expected 0");
                end else begin
                    chk("err_idx", int'(last_code[2:0]), eq.pop_front());
                end
                chk("err_irq", int'(bus.irq), 0);
            end
            if (gq.size() != 0) begin
                checks++; errors++;
                $display("FAIL missed_grant: got none expected code %0d", gq[0]);
                gq.delete();
            end
            if (eq.size() != 0) begin
                checks++; errors++;
                $display("FAIL missed_err: got err=0 expected idx %0d", eq[0]);
                eq.delete();
            end
            prev_irq = bus.irq;
        end
    end

    task automatic do_ack();
        for (int i = 0; i < 60 && !bus.irq; i++) @(negedge clk);
        chk("irq_wait", int'(bus.irq), 1);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    task automatic chk_seen(input string n, input int pos, input int exp);
        if (pos < seen.size()) chk(n, seen[pos], exp);
        else chk(n, -1, exp);
    endtask

    int base;
    int cyc;

    initial begin
        bus.req = '0; bus.mask = '0; bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_irq", int'(bus.irq), 0);
        chk("rst_code", int'(bus.code), 0);
        chk("rst_pend", int'(bus.pend), 0);
        chk("rst_err", int'(bus.err), 0);
        rst_n = 1'b1;

        // single request, exact latency
        @(negedge clk) bus.req = 8'h08;
        @(negedge clk);
        chk("t2_pend", int'(bus.pend), 8'h08);
        chk("t2_irq_k", int'(bus.irq), 0);
        @(negedge clk);
        chk("t2_irq_arb", int'(bus.irq), 0);
        @(negedge clk);
        chk("t2_code", int'(bus.code), 4'b1011);
        chk("t2_irq", int'(bus.irq), 1);
        bus.ack = 1'b1;
        @(negedge clk) bus.ack = 1'b0;
        chk("t2_code_off", int'(bus.code), 0);
        chk("t2_pend_off", int'(bus.pend), 0);

        // asynchronous reset mid-grant
        bus.req = '0;
        @(negedge clk) bus.req = 8'h08;
        repeat (3) @(negedge clk);
        chk("t1_code_pre", int'(bus.code), 4'b1011);
        #2 rst_n = 1'b0; bus.req = '0;
        #1;
        chk("t1_irq", int'(bus.irq), 0);
        chk("t1_code", int'(bus.code), 0);
        chk("t1_pend", int'(bus.pend), 0);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;

        // round robin 0, 3, 6
        base = seen.size();
        @(negedge clk) bus.req = 8'h49;
        repeat (3) do_ack();
        chk_seen("t3_g0", base, 4'b1000);
        chk_seen("t3_g1", base + 1, 4'b1011);
        chk_seen("t3_g2", base + 2, 4'b1110);
        @(negedge clk) chk("t3_pend", int'(bus.pend), 0);

        // wrap from pointer 7
        bus.req = '0;
        base = seen.size();
        @(negedge clk) bus.req = 8'h82;
        repeat (2) do_ack();
        chk_seen("t4_g0", base, 4'b1111);
        chk_seen("t4_g1", base + 1, 4'b1001);

        // mask holds everything but source 0
        bus.req = '0; bus.mask = 8'hFE;
        base = seen.size();
        @(negedge clk) bus.req = 8'hFF;
        do_ack();
        chk_seen("t5_g0", base, 4'b1000);
        repeat (6) @(negedge clk);
        chk("t5_idle_irq", int'(bus.irq), 0);
        chk("t5_pend", int'(bus.pend), 8'hFE);
        bus.mask = '0;
        repeat (7) do_ack();
        for (int i = 1; i < 8; i++) chk_seen("t5_resume", base + i, 8 + i);

        // timeout on source 5, then the others go first
        bus.req = '0;
        base = seen.size();
        @(negedge clk) bus.req = 8'h20;
        for (int i = 0; i < 60 && !bus.irq; i++) @(negedge clk);
        chk("t6_irq", int'(bus.irq), 1);
        bus.req = 8'h64;
        cyc = 0;
        for (int i = 1; i <= 10 && !bus.err; i++) begin
            @(negedge clk);
            cyc = i;
        end
        chk("t6_err_delay", cyc, TO);
        chk("t6_pend5", int'(bus.pend[5]), 1);
        chk("t6_irq_drop", int'(bus.irq), 0);
        @(negedge clk) chk("t6_err_pulse", int'(bus.err), 0);
        repeat (3) do_ack();
        chk_seen("t6_g0", base, 4'b1101);
        chk_seen("t6_g1", base + 1, 4'b1110);
        chk_seen("t6_g2", base + 2, 4'b1010);
        chk_seen("t6_g3", base + 3, 4'b1101);

        // random traffic against the model
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                bus.req = bus.req ^ 8'(1 << $urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0)
                bus.mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            bus.ack = ($urandom_range(0, 2) == 0);
        end
        bus.ack = 1'b0; bus.mask = '0;
        repeat (10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
